// File: rtl/vj_pkg.sv
// Shared definitions for the Viola-Jones window standard-deviation unit:
// window geometry, pixel width, the tile array type and the FSM state set.
package vj_pkg;

  localparam int WINDOW_SIZE = 24;
  localparam int PIX_W       = 8;

  // Window area W*W, used to scale the square sum before subtracting S^2.
  localparam logic [63:0] WIN_AREA = 64'(WINDOW_SIZE * WINDOW_SIZE);

  // One (W+1)x(W+1) tile of 32-bit words, indexed [row][col].
  typedef logic [31:0] tile_t [0:WINDOW_SIZE][0:WINDOW_SIZE];

  // Control flow: IDLE -> INT (1) -> VAR (1) -> SQRT (32 + hand-off) -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT  = 2'd1,
    ST_VAR  = 2'd2,
    ST_SQRT = 2'd3
  } state_e;

  // Pixel word reduced to its meaningful PIX_W bits.
  function automatic logic [31:0] pix_val(input logic [31:0] w);
    return {{(32-PIX_W){1'b0}}, w[PIX_W-1:0]};
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: 64-bit radicand -> 32-bit root.
// 'start' loads the radicand; one root bit is resolved per clock, MSB first.
// After 32 iterations 'done' is high for one cycle with the root on 'result'.
module isqrt_seq
  import vj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] radicand,
  output logic        done,
  output logic [31:0] result
);

  logic [63:0] rad_q;
  logic [35:0] rem_q;
  logic [31:0] root_q;
  logic [5:0]  iter_q;
  logic        busy_q;

  logic [35:0] rem_shift;
  logic [35:0] trial;
  logic        fits;

  // Bring down the next two radicand bits and test the trial divisor 4*root+1.
  always_comb begin
    rem_shift = {rem_q[33:0], rad_q[63:62]};
    trial     = {2'b00, root_q, 2'b01};
    fits      = (rem_shift >= trial);
  end

  // Iteration registers; a new start always wins over an iteration in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      iter_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (iter_q != 6'd32) begin
        rad_q  <= {rad_q[61:0], 2'b00};
        rem_q  <= fits ? (rem_shift - trial) : rem_shift;
        root_q <= {root_q[30:0], fits};
        iter_q <= iter_q + 6'd1;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done   = busy_q && (iter_q == 6'd32);
  assign result = root_q;

endmodule

// File: rtl/window_std_dev_unit.sv
// Window standard deviation for Haar threshold normalisation.
// Latches a (W+1)x(W+1) tile, registers its integral and squared integral
// images, forms the W x W region variance from the four corners and returns
// floor(sqrt(variance)) through a bit-serial square root.
// Build option WIN_STD_DEV_DBG_EN adds registered corner / partial-product
// debug outputs and the FSM state.
//
// Handshake: a tile is taken on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, so in_valid is ignored while busy (no
// queueing). out_valid is a single-cycle strobe; scan_win_std_dev holds.
module window_std_dev_unit
  import vj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  tile_t       input_img,
  output logic        out_valid,
  output tile_t       scan_win,
  output tile_t       scan_win_sq,
  output logic [31:0] scan_win_std_dev
`ifdef WIN_STD_DEV_DBG_EN
  ,
  output logic [31:0] dbg_top_left,
  output logic [31:0] dbg_top_right,
  output logic [31:0] dbg_bottom_left,
  output logic [31:0] dbg_bottom_right,
  output logic [63:0] dbg_std_dev1,
  output logic [63:0] dbg_std_dev2,
  output state_e      dbg_state
`endif
);

  localparam int W = WINDOW_SIZE;

  state_e      state_q, state_d;
  tile_t       img_q;
  tile_t       int_q, int_d;
  tile_t       sq_q, sq_d;
  logic [31:0] col_prev [0:WINDOW_SIZE];
  logic [31:0] col_prev_sq [0:WINDOW_SIZE];
  logic [31:0] row_acc, row_acc_sq, pix;
  logic        out_valid_q;
  logic [31:0] std_dev_q;

  logic [31:0] reg_sum, reg_sq_sum;
  logic [63:0] std_dev1, std_dev2, variance;
  logic        sqrt_start, sqrt_done;
  logic [31:0] sqrt_root;

  // Next-state logic for the IDLE/INT/VAR/SQRT sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_INT;
      ST_INT:  state_d = ST_VAR;
      ST_VAR:  state_d = ST_SQRT;
      ST_SQRT: if (sqrt_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, accepted-tile latch and result/strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      std_dev_q   <= '0;
      for (int i = 0; i <= W; i++)
        for (int j = 0; j <= W; j++)
          img_q[i][j] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == ST_SQRT) && sqrt_done;
      if ((state_q == ST_SQRT) && sqrt_done)
        std_dev_q <= sqrt_root;
      if ((state_q == ST_IDLE) && in_valid)
        img_q <= input_img;
    end
  end

  // Inclusive integral images: each row's running sum plus the cell above.
  always_comb begin
    int_d       = '{default: '0};
    sq_d        = '{default: '0};
    col_prev    = '{default: '0};
    col_prev_sq = '{default: '0};
    row_acc     = '0;
    row_acc_sq  = '0;
    pix         = '0;
    for (int i = 0; i <= W; i++) begin
      row_acc    = '0;
      row_acc_sq = '0;
      for (int j = 0; j <= W; j++) begin
        pix            = pix_val(img_q[i][j]);
        row_acc        = row_acc + pix;
        row_acc_sq     = row_acc_sq + pix * pix;
        int_d[i][j]    = row_acc + col_prev[j];
        sq_d[i][j]     = row_acc_sq + col_prev_sq[j];
        col_prev[j]    = int_d[i][j];
        col_prev_sq[j] = sq_d[i][j];
      end
    end
  end

  // Integral images are captured in INT and held until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= W; i++)
        for (int j = 0; j <= W; j++) begin
          int_q[i][j] <= '0;
          sq_q[i][j]  <= '0;
        end
    end else if (state_q == ST_INT) begin
      int_q <= int_d;
      sq_q  <= sq_d;
    end
  end

  // Region sums over rows/cols 1..W and the clamped variance W^2*Q - S^2.
  always_comb begin
    reg_sum    = int_q[W][W] - int_q[0][W] - int_q[W][0] + int_q[0][0];
    reg_sq_sum = sq_q[W][W] - sq_q[0][W] - sq_q[W][0] + sq_q[0][0];
    std_dev1   = WIN_AREA * {32'd0, reg_sq_sum};
    std_dev2   = {32'd0, reg_sum} * {32'd0, reg_sum};
    variance   = (std_dev1 > std_dev2) ? (std_dev1 - std_dev2) : 64'd0;
  end

  // The square-root unit captures the variance at the end of VAR.
  assign sqrt_start = (state_q == ST_VAR);

  isqrt_seq u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sqrt_start),
    .radicand (variance),
    .done     (sqrt_done),
    .result   (sqrt_root)
  );

`ifdef WIN_STD_DEV_DBG_EN
  // Debug snapshot of corners and partial products, taken with the variance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_top_left     <= '0;
      dbg_top_right    <= '0;
      dbg_bottom_left  <= '0;
      dbg_bottom_right <= '0;
      dbg_std_dev1     <= '0;
      dbg_std_dev2     <= '0;
    end else if (state_q == ST_VAR) begin
      dbg_top_left     <= int_q[0][0];
      dbg_top_right    <= int_q[0][W];
      dbg_bottom_left  <= int_q[W][0];
      dbg_bottom_right <= int_q[W][W];
      dbg_std_dev1     <= std_dev1;
      dbg_std_dev2     <= std_dev2;
    end
  end

  assign dbg_state = state_q;
`endif

  assign in_ready         = (state_q == ST_IDLE);
  assign out_valid        = out_valid_q;
  assign scan_win         = int_q;
  assign scan_win_sq      = sq_q;
  assign scan_win_std_dev = std_dev_q;

endmodule

// File: tb/tb_window_std_dev_unit.sv
// Bench for window_std_dev_unit: directed tiles with hand-computed results,
// expected results queued at issue and checked by an independent monitor.
module tb_window_std_dev_unit;
  import vj_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        in_ready;
  tile_t       input_img;
  logic        out_valid;
  tile_t       scan_win;
  tile_t       scan_win_sq;
  logic [31:0] scan_win_std_dev;
`ifdef WIN_STD_DEV_DBG_EN
  logic [31:0] dbg_tl, dbg_tr, dbg_bl, dbg_br;
  logic [63:0] dbg_d1, dbg_d2;
  state_e      dbg_st;
`endif

  window_std_dev_unit dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .input_img        (input_img),
    .out_valid        (out_valid),
    .scan_win         (scan_win),
    .scan_win_sq      (scan_win_sq),
    .scan_win_std_dev (scan_win_std_dev)
`ifdef WIN_STD_DEV_DBG_EN
    ,
    .dbg_top_left     (dbg_tl),
    .dbg_top_right    (dbg_tr),
    .dbg_bottom_left  (dbg_bl),
    .dbg_bottom_right (dbg_br),
    .dbg_std_dev1     (dbg_d1),
    .dbg_std_dev2     (dbg_d2),
    .dbg_state        (dbg_st)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          tests_run = 0;
  int          fails     = 0;
  int          edge_cnt  = 0;
  int          out_cnt   = 0;
  int          push_cnt  = 0;
  int          last_acc  = 0;
  logic [31:0] exp_q[$];
  int          exp_edge_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // kind 0: all 2; 1: region checkerboard 0/255; 2: only [24][24]=255;
  // kind 3: row 0 / col 0 = 255, rest 2.
  task automatic build(input int kind, output tile_t t);
    for (int r = 0; r <= WINDOW_SIZE; r++)
      for (int c = 0; c <= WINDOW_SIZE; c++) begin
        case (kind)
          0: t[r][c] = 32'd2;
          1: t[r][c] = (r >= 1 && c >= 1 && ((r + c) % 2 == 1)) ? 32'd255 : 32'd0;
          2: t[r][c] = (r == WINDOW_SIZE && c == WINDOW_SIZE) ? 32'd255 : 32'd0;
          default: t[r][c] = (r == 0 || c == 0) ? 32'd255 : 32'd2;
        endcase
      end
  endtask

  // Waits for in_ready, issues one tile, queues its expected result, and
  // checks the registered integral-image corner one edge after acceptance.
  task automatic send(input int kind, input logic [31:0] exp_std,
                      input logic [31:0] exp_br, input logic [31:0] exp_br_sq);
    tile_t t;
    int    n;
    build(kind, t);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", in_ready, 1);
    input_img = t;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    last_acc = edge_cnt;
    exp_q.push_back(exp_std);
    exp_edge_q.push_back(edge_cnt + 35);
    push_cnt++;
    in_valid = 1'b0;
    check("in_ready_low_after_accept", in_ready, 0);
    @(posedge clk);
    #1;
    check("scan_win_br", scan_win[WINDOW_SIZE][WINDOW_SIZE], exp_br);
    check("scan_win_sq_br", scan_win_sq[WINDOW_SIZE][WINDOW_SIZE], exp_br_sq);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        logic [31:0] e;
        int          ed;
        e  = exp_q.pop_front();
        ed = exp_edge_q.pop_front();
        check("std_dev", scan_win_std_dev, e);
        check("out_valid_edge", edge_cnt, ed);
        check("in_ready_with_out_valid", in_ready, 1);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int saved_out;
    int prev_acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    input_img = '{default: '0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_std_dev", scan_win_std_dev, 0);
    check("reset_scan_win", scan_win[WINDOW_SIZE][WINDOW_SIZE], 0);
    check("reset_scan_win_sq", scan_win_sq[WINDOW_SIZE][WINDOW_SIZE], 0);
    check("reset_scan_win_00", scan_win[0][0], 0);

    // All pixels 2: zero variance.
    send(0, 32'd0, 32'd1250, 32'd2500);
    check("scan_win_2_3", scan_win[2][3], 24);
    drain();

    // Region checkerboard 0/255.
    send(1, 32'd73440, 32'd73440, 32'd18727200);
    drain();

    // Single bright pixel in the bottom-right corner.
    send(2, 32'd6114, 32'd255, 32'd65025);
    drain();

    // Bright border row/col must not influence the result.
    send(3, 32'd0, 32'd13647, 32'd3188529);
    drain();

    // in_valid held with another tile while busy: ignored.
    send(0, 32'd0, 32'd1250, 32'd2500);
    @(negedge clk);
    build(1, input_img);
    in_valid = 1'b1;
    repeat (25) @(negedge clk);
    in_valid = 1'b0;
    drain();
    check("single_out_valid_count", out_cnt, push_cnt);
    check("scan_win_held", scan_win[WINDOW_SIZE][WINDOW_SIZE], 1250);

    // Back-to-back tiles at k and k+36.
    send(2, 32'd6114, 32'd255, 32'd65025);
    prev_acc = last_acc;
    send(1, 32'd73440, 32'd73440, 32'd18727200);
    check("back_to_back_accept_edge", last_acc, prev_acc + 36);
    drain();

    // Reset in the middle of the square root.
    send(1, 32'd73440, 32'd73440, 32'd18727200);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_edge_q.delete();
    push_cnt--;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_std_dev", scan_win_std_dev, 0);
    check("midreset_scan_win", scan_win[WINDOW_SIZE][WINDOW_SIZE], 0);
    check("midreset_scan_win_sq", scan_win_sq[WINDOW_SIZE][WINDOW_SIZE], 0);
    saved_out = out_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("no_out_after_reset", out_cnt, saved_out);
    send(2, 32'd6114, 32'd255, 32'd65025);
    drain();

    check("total_out_valid_count", out_cnt, push_cnt);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_std_dev_unit.md
# window_std_dev_unit

Computes the pixel standard deviation of one Viola-Jones scan window for normalising Haar feature thresholds. It accepts a (WINDOW_SIZE+1)×(WINDOW_SIZE+1) pixel tile and builds the integral image and squared integral image. From those it derives the WINDOW_SIZE×WINDOW_SIZE region variance and returns its integer square root. It sits between the image-pyramid scanner and the classifier-cascade stages.

## Interface
- WINDOW_SIZE, 24: window edge; tile edge is WINDOW_SIZE+1.
- PIX_W, 8: pixel width. Pixels are stored zero-extended in 32-bit words.
- clk  input  1: sole clock; all state changes on rising edge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: tile present; accepted when in_valid && in_ready at a rising edge.
- in_ready  output  1: high when idle.
- input_img  input  (WINDOW_SIZE+1)²×32: tile, indexed [row][col].
- out_valid  output  1: one-cycle result strobe.
- scan_win  output  (WINDOW_SIZE+1)²×32: registered integral image.
- scan_win_sq  output  (WINDOW_SIZE+1)²×32: registered squared integral image.
- scan_win_std_dev  output  32: floor(sqrt(variance)), held until next result.

## Operation
- Integral image, inclusive: scan_win[i][j] = Σ input_img[r][c] over r≤i, c≤j. scan_win_sq uses the same sum of input_img[r][c]². All sums are 32-bit unsigned and wrap modulo 2³². This cannot occur for PIX_W=8 and WINDOW_SIZE=24.
- Corners: TL=[0][0], TR=[0][W], BL=[W][0], BR=[W][W], where W=WINDOW_SIZE.
- Region sum S = BR−TR−BL+TL of scan_win. Region square sum Q is the same expression on scan_win_sq. Both cover rows 1..W and cols 1..W only; row 0 and col 0 never affect the result.
- std_dev1 = W²·Q (64-bit). std_dev2 = S² (64-bit). Variance = std_dev1 − std_dev2, clamped to 0 if negative.
- Result = floor(sqrt(variance)), computed over 64 bits with a 32-bit result by a bit-serial restoring square root (one result bit per cycle, MSB first).

## Timing
- Reset values: in_ready=1, out_valid=0, scan_win=0, scan_win_sq=0, scan_win_std_dev=0. Any in-flight computation is discarded.
- Edge k: tile accepted; in_ready drops.
- Edge k+1: scan_win and scan_win_sq registered; they remain valid until the next acceptance.
- Edge k+2: variance registered.
- Edges k+3…k+34: 32 square-root iterations.
- Edge k+35: scan_win_std_dev updated, out_valid=1 for exactly one cycle, in_ready=1.
- The earliest next acceptance is edge k+36; throughput is one tile per 36 cycles.
- in_valid while in_ready=0 is ignored. There is no queueing.
- States: IDLE → INT (1 cycle) → VAR (1 cycle) → SQRT (32 cycles) → IDLE. out_valid is asserted on the SQRT→IDLE transition. Reset from any state returns to IDLE.

## Configuration
- WIN_STD_DEV_DBG_EN defined: adds 32-bit outputs dbg_top_left, dbg_top_right, dbg_bottom_left and dbg_bottom_right (scan_win corners), plus 64-bit dbg_std_dev1 and dbg_std_dev2. All are registered with the VAR stage and reset to 0.
- WIN_STD_DEV_DBG_EN undefined: these ports and their registers are absent. Functional behaviour is identical.

## Structure
- Shared package vj_pkg: WINDOW_SIZE, PIX_W, window tile typedef (array of 32-bit words), state enum.
- One sub-module: isqrt_seq, the 64→32 sequential restoring square root. Its ports are start, done and result.
- Integral-image generation stays inline in the top module.

## Test plan
- All pixels = 2 → scan_win[i][j] = 2(i+1)(j+1), so [24][24]=1250. scan_win_sq[24][24]=2500. S=1152, Q=2304, variance 0, std_dev=0. out_valid at edge k+35.
- Region checkerboard 0/255 (288 of each) → S=73440, Q=18727200, variance 5393433600, std_dev=73440.
- Only pixel [24][24]=255, rest 0 → variance 37389375, std_dev=6114.
- Row 0 and col 0 = 255, rest 2 → std_dev=0 (border excluded).
- Second in_valid held during SQRT → ignored, single out_valid. Back-to-back tiles accepted at k and k+36 → two results, correct values.
- rst asserted mid-SQRT → all outputs 0 and in_ready=1 immediately. No out_valid follows. The next tile computes correctly.
